// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one fixed-latency, in-order multiplier among NUM_REQ requesters.
// A tag FIFO records the owner of each issued operation so results are routed back in issue order.
module mult_arbiter #(
    parameter int DATAWIDTH       = 4,
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]         req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]         req_b,
    output logic                                 mul_i_valid,
    output logic [DATAWIDTH-1:0]                 mul_A,
    output logic [DATAWIDTH-1:0]                 mul_B,
    input  logic                                 mul_o_valid,
    input  logic [2*DATAWIDTH-1:0]               mul_Z,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [2*DATAWIDTH-1:0]               rsp_z,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_underflow
);
    localparam int TW = $clog2(NUM_REQ);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING+1);

    logic [TW-1:0]          last_q, gnt_idx;
    logic                   gnt_found, hs, pop;
    logic [OW-1:0]          out_q, out_d;
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0]          tag_q [MAX_OUTSTANDING];
    logic                   mul_v_q, err_q;
    logic [DATAWIDTH-1:0]   mul_a_q, mul_b_q;
    logic [NUM_REQ-1:0]     rsp_v_q;
    logic [2*DATAWIDTH-1:0] rsp_z_q;

    // search starts just after the last winner so every requester gets a turn
    always_comb begin : arb
        int j;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[TW'(j)]) begin
                gnt_found = 1'b1;
                gnt_idx   = TW'(j);
            end
        end
    end

    // credit check uses only the registered count, never this cycle's returning result
    assign req_ready = (rst && gnt_found && out_q < OW'(MAX_OUTSTANDING)) ? NUM_REQ'(1) << gnt_idx : '0;
    assign hs        = |(req_valid & req_ready);
    assign pop       = mul_o_valid && out_q != '0;
    assign out_d     = out_q + OW'(hs) - OW'(pop);
    assign wr_d      = hs  ? ((wr_q == PW'(MAX_OUTSTANDING-1)) ? '0 : wr_q + PW'(1)) : wr_q;
    assign rd_d      = pop ? ((rd_q == PW'(MAX_OUTSTANDING-1)) ? '0 : rd_q + PW'(1)) : rd_q;

    always_ff @(posedge clk) begin
        if (hs) tag_q[wr_q] <= gnt_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= TW'(NUM_REQ-1);
            out_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            mul_v_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            rsp_v_q <= '0;
            rsp_z_q <= '0;
            err_q   <= 1'b0;
        end else begin
            last_q  <= hs ? gnt_idx : last_q;
            out_q   <= out_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mul_v_q <= hs;
            mul_a_q <= hs ? req_a[gnt_idx*DATAWIDTH +: DATAWIDTH] : mul_a_q;
            mul_b_q <= hs ? req_b[gnt_idx*DATAWIDTH +: DATAWIDTH] : mul_b_q;
            rsp_v_q <= pop ? NUM_REQ'(1) << tag_q[rd_q] : '0;
            rsp_z_q <= pop ? mul_Z : rsp_z_q;
            err_q   <= err_q | (mul_o_valid && out_q == '0);
        end
    end

    assign mul_i_valid   = mul_v_q;
    assign mul_A         = mul_a_q;
    assign mul_B         = mul_b_q;
    assign rsp_valid     = rsp_v_q;
    assign rsp_z         = rsp_z_q;
    assign outstanding   = out_q;
    assign err_underflow = err_q;
endmodule
